// File: rtl/i2c_slave_bus_sync_if.sv
// I2C slave bus front-end interface: raw pins in, clean levels and strobes out.
// slave = the synchroniser block, master = pin driver / downstream consumer.
interface i2c_slave_bus_sync_if;
    logic scl_in;
    logic sda_in;
    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic bit_valid;
    logic bit_data;
    logic start_det;
    logic rstart_det;
    logic stop_det;
    logic timeout;
    logic bus_busy;

    modport master (
        output scl_in, sda_in,
        input  scl_s, sda_s, scl_rise, scl_fall,
        input  bit_valid, bit_data,
        input  start_det, rstart_det, stop_det,
        input  timeout, bus_busy
    );

    modport slave (
        input  scl_in, sda_in,
        output scl_s, sda_s, scl_rise, scl_fall,
        output bit_valid, bit_data,
        output start_det, rstart_det, stop_det,
        output timeout, bus_busy
    );
endinterface

// File: rtl/i2c_slave_bus_sync.sv
// I2C slave bus front end: pin sync, optional glitch filter, START/STOP/edge
// detection, bus-busy tracking, SCL-low timeout. Filter: I2C_GLITCH_FILTER_EN.
module i2c_slave_bus_sync #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TO_CNT_W       = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic                 clk,
    input logic                 rst_n,
    i2c_slave_bus_sync_if.slave bus
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    if (SYNC_STAGES < 2 || FILTER_LEN < 1 || TO_CNT_W < 1) begin : g_param_check
        $error("i2c_slave_bus_sync: illegal parameter value");
    end

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_y;
    logic                   sda_y;
    logic                   scl_nx;
    logic                   sda_nx;
    logic                   scl_q;
    logic                   sda_q;
    logic [TO_CNT_W-1:0]    to_cnt;
    logic                   start_c;
    logic                   stop_c;
    logic                   to_c;
    logic                   rise_c;
    logic                   fall_c;

    logic scl_rise_q;
    logic scl_fall_q;
    logic bit_valid_q;
    logic bit_data_q;
    logic start_q;
    logic rstart_q;
    logic stop_q;
    logic timeout_q;
    logic busy_q;

    // Metastability chains, reset to the idle-high bus level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
        end
    end

    assign scl_y = scl_sync[SYNC_STAGES-1];
    assign sda_y = sda_sync[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
    localparam int FC_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_LEN - 1);

    logic [FC_W-1:0] scl_fc;
    logic [FC_W-1:0] sda_fc;
    logic            scl_flip;
    logic            sda_flip;

    // A level only flips on the FILTER_LEN-th consecutive differing sample
    assign scl_flip = (scl_y != scl_q) && (scl_fc == FC_LAST);
    assign sda_flip = (sda_y != sda_q) && (sda_fc == FC_LAST);
    assign scl_nx   = scl_flip ? scl_y : scl_q;
    assign sda_nx   = sda_flip ? sda_y : sda_q;

    // Run-length counters of disagreement between sync output and filtered level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_fc <= '0;
            sda_fc <= '0;
        end else begin
            if (scl_y == scl_q || scl_flip)
                scl_fc <= '0;
            else
                scl_fc <= scl_fc + 1'b1;
            if (sda_y == sda_q || sda_flip)
                sda_fc <= '0;
            else
                sda_fc <= sda_fc + 1'b1;
        end
    end
`else
    assign scl_nx = scl_y;
    assign sda_nx = sda_y;
`endif

    // Events are judged on the transition into the next registered level
    assign rise_c  = scl_nx & ~scl_q;
    assign fall_c  = ~scl_nx & scl_q;
    assign start_c = scl_q & scl_nx & sda_q & ~sda_nx;
    assign stop_c  = scl_q & scl_nx & ~sda_q & sda_nx;
    assign to_c    = TO_EN && (state == BUSY) && !scl_q && (to_cnt == TO_LAST);

    // Clean levels, edge strobes and sampled data bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
            scl_rise_q  <= 1'b0;
            scl_fall_q  <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_data_q  <= 1'b0;
        end else begin
            scl_q       <= scl_nx;
            sda_q       <= sda_nx;
            scl_rise_q  <= rise_c;
            scl_fall_q  <= fall_c;
            bit_valid_q <= rise_c;
            if (rise_c)
                bit_data_q <= sda_nx;
        end
    end

    // Bus state FSM; START/STOP need SCL high so they never coincide with timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            rstart_q  <= 1'b0;
            stop_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            start_q   <= 1'b0;
            rstart_q  <= 1'b0;
            stop_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (stop_c) begin
                        stop_q <= 1'b1;
                    end else if (start_c) begin
                        state   <= BUSY;
                        busy_q  <= 1'b1;
                        start_q <= 1'b1;
                    end
                end
                BUSY: begin
                    unique case (1'b1)
                        stop_c: begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            stop_q <= 1'b1;
                        end
                        start_c: begin
                            start_q  <= 1'b1;
                            rstart_q <= 1'b1;
                        end
                        to_c: begin
                            state     <= IDLE;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // SCL-low watchdog, only counting while a transfer is in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (!TO_EN || state == IDLE || scl_q || to_c) begin
            to_cnt <= '0;
        end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign bus.scl_s      = scl_q;
    assign bus.sda_s      = sda_q;
    assign bus.scl_rise   = scl_rise_q;
    assign bus.scl_fall   = scl_fall_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.bit_data   = bit_data_q;
    assign bus.start_det  = start_q;
    assign bus.rstart_det = rstart_q;
    assign bus.stop_det   = stop_q;
    assign bus.timeout    = timeout_q;
    assign bus.bus_busy   = busy_q;

endmodule

// File: tb/tb_i2c_slave_bus_sync.sv
// Testbench for i2c_slave_bus_sync: event scoreboard per scenario.
// Expected events queued with stimulus, matched against logged DUT strobes.
module tb_i2c_slave_bus_sync;

    localparam int TO = 100;
    localparam int EV_START  = 1;
    localparam int EV_RSTART = 2;
    localparam int EV_STOP   = 3;
    localparam int EV_TO     = 4;
    localparam int EV_FALL   = 5;
    localparam int EV_RISE   = 6;
    localparam int EV_BIT    = 7;

    typedef struct {
        int   kind;
        logic data;
        int   cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    i2c_slave_bus_sync_if bus ();

    i2c_slave_bus_sync #(
        .SYNC_STAGES(2),
        .FILTER_LEN(4),
        .TO_CNT_W(16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic ev_t mk(int k, logic d, int c);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.cyc  = c;
        return e;
    endfunction

    function automatic void push(int k, logic d);
        exp_q.push_back(mk(k, d, 0));
    endfunction

    // Log every strobe seen, in a fixed per-cycle order
    always @(negedge clk) begin
        cyc++;
        if (bus.start_det)  obs_q.push_back(mk(EV_START, 1'b0, cyc));
        if (bus.rstart_det) obs_q.push_back(mk(EV_RSTART, 1'b0, cyc));
        if (bus.stop_det)   obs_q.push_back(mk(EV_STOP, 1'b0, cyc));
        if (bus.timeout)    obs_q.push_back(mk(EV_TO, 1'b0, cyc));
        if (bus.scl_fall)   obs_q.push_back(mk(EV_FALL, 1'b0, cyc));
        if (bus.scl_rise)   obs_q.push_back(mk(EV_RISE, 1'b0, cyc));
        if (bus.bit_valid)  obs_q.push_back(mk(EV_BIT, bus.bit_data, cyc));
    end

    task automatic clk_n(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic any;
        rst_n = 1'b0;
        bus.scl_in = 1'b1;
        bus.sda_in = 1'b1;
        clk_n(5);
        any = bus.scl_rise | bus.scl_fall | bus.bit_valid | bus.start_det |
              bus.rstart_det | bus.stop_det | bus.timeout;
        tests++;
        if ({bus.scl_s, bus.sda_s} !== 2'b11) begin
            failed++;
            $display("FAIL reset_levels: got %b%b want 11", bus.scl_s, bus.sda_s);
        end
        tests++;
        if (any !== 1'b0) begin
            failed++;
            $display("FAIL reset_strobes: got %b want 0", any);
        end
        tests++;
        if ({bus.bus_busy, bus.bit_data} !== 2'b00) begin
            failed++;
            $display("FAIL reset_busy_data: got %b%b want 00", bus.bus_busy, bus.bit_data);
        end
        obs_q.delete();
        rst_n = 1'b1;
        clk_n(10);
        tests++;
        if (obs_q.size() != 0) begin
            failed++;
            $display("FAIL reset_quiet: got %0d events want 0", obs_q.size());
        end
    endtask

    task automatic test_byte();
        ev_t e;
        ev_t o;
        logic [7:0] b;
        b = 8'hB6;
        exp_q.delete();
        obs_q.delete();
        tests++;
        if (bus.bus_busy !== 1'b0) begin
            failed++;
            $display("FAIL byte_busy_pre: got %b want 0", bus.bus_busy);
        end
        bus.sda_in = 1'b0;
        push(EV_START, 1'b0);
        clk_n(20);
        tests++;
        if (bus.bus_busy !== 1'b1) begin
            failed++;
            $display("FAIL byte_busy_start: got %b want 1", bus.bus_busy);
        end
        for (int i = 7; i >= 0; i--) begin
            bus.scl_in = 1'b0;
            push(EV_FALL, 1'b0);
            clk_n(10);
            bus.sda_in = b[i];
            clk_n(10);
            bus.scl_in = 1'b1;
            push(EV_RISE, 1'b0);
            push(EV_BIT, b[i]);
            clk_n(20);
        end
        tests++;
        if (bus.bus_busy !== 1'b1) begin
            failed++;
            $display("FAIL byte_busy_mid: got %b want 1", bus.bus_busy);
        end
        bus.scl_in = 1'b0;
        push(EV_FALL, 1'b0);
        clk_n(10);
        bus.sda_in = 1'b0;
        clk_n(10);
        bus.scl_in = 1'b1;
        push(EV_RISE, 1'b0);
        push(EV_BIT, 1'b0);
        clk_n(10);
        bus.sda_in = 1'b1;
        push(EV_STOP, 1'b0);
        clk_n(20);
        tests++;
        if (bus.bus_busy !== 1'b0) begin
            failed++;
            $display("FAIL byte_busy_post: got %b want 0", bus.bus_busy);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                failed++;
                $display("FAIL byte_ev: got none want kind %0d", e.kind);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.data !== e.data) begin
                    failed++;
                    $display("FAIL byte_ev: got %0d/%b want %0d/%b", o.kind, o.data, e.kind, e.data);
                end
            end
        end
        tests++;
        if (obs_q.size() != 0) begin
            failed++;
            $display("FAIL byte_extra: got %0d events want 0", obs_q.size());
        end
    endtask

    task automatic test_glitch();
        ev_t e;
        ev_t o;
        logic saw_low;
        logic want_low;
        exp_q.delete();
        obs_q.delete();
        bus.sda_in = 1'b0;
        push(EV_START, 1'b0);
        clk_n(20);
        bus.scl_in = 1'b0;
        clk_n(2);
        bus.scl_in = 1'b1;
`ifdef I2C_GLITCH_FILTER_EN
        want_low = 1'b0;
`else
        want_low = 1'b1;
        push(EV_FALL, 1'b0);
        push(EV_RISE, 1'b0);
        push(EV_BIT, 1'b0);
`endif
        saw_low = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus.scl_s === 1'b0) saw_low = 1'b1;
        end
        tests++;
        if (saw_low !== want_low) begin
            failed++;
            $display("FAIL glitch_scl_low: got %b want %b", saw_low, want_low);
        end
        bus.sda_in = 1'b1;
        push(EV_STOP, 1'b0);
        clk_n(20);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                failed++;
                $display("FAIL glitch_ev: got none want kind %0d", e.kind);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.data !== e.data) begin
                    failed++;
                    $display("FAIL glitch_ev: got %0d/%b want %0d/%b", o.kind, o.data, e.kind, e.data);
                end
            end
        end
        tests++;
        if (obs_q.size() != 0) begin
            failed++;
            $display("FAIL glitch_extra: got %0d events want 0", obs_q.size());
        end
    endtask

    task automatic test_rstart();
        ev_t e;
        ev_t o;
        int cs;
        int cr;
        cs = -2;
        cr = -1;
        exp_q.delete();
        obs_q.delete();
        bus.sda_in = 1'b0;
        push(EV_START, 1'b0);
        clk_n(20);
        bus.scl_in = 1'b0;
        push(EV_FALL, 1'b0);
        clk_n(10);
        bus.sda_in = 1'b1;
        clk_n(10);
        bus.scl_in = 1'b1;
        push(EV_RISE, 1'b0);
        push(EV_BIT, 1'b1);
        clk_n(10);
        bus.sda_in = 1'b0;
        push(EV_START, 1'b0);
        push(EV_RSTART, 1'b0);
        clk_n(20);
        tests++;
        if (bus.bus_busy !== 1'b1) begin
            failed++;
            $display("FAIL rstart_busy: got %b want 1", bus.bus_busy);
        end
        bus.scl_in = 1'b0;
        push(EV_FALL, 1'b0);
        clk_n(20);
        bus.scl_in = 1'b1;
        push(EV_RISE, 1'b0);
        push(EV_BIT, 1'b0);
        clk_n(10);
        bus.sda_in = 1'b1;
        push(EV_STOP, 1'b0);
        clk_n(20);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                failed++;
                $display("FAIL rstart_ev: got none want kind %0d", e.kind);
            end else begin
                o = obs_q.pop_front();
                if (o.kind == EV_START && cr < 0) cs = o.cyc;
                if (o.kind == EV_RSTART) cr = o.cyc;
                if (o.kind !== e.kind || o.data !== e.data) begin
                    failed++;
                    $display("FAIL rstart_ev: got %0d/%b want %0d/%b", o.kind, o.data, e.kind, e.data);
                end
            end
        end
        tests++;
        if (cr !== cs) begin
            failed++;
            $display("FAIL rstart_same_cycle: got rstart@%0d want start@%0d", cr, cs);
        end
        tests++;
        if (obs_q.size() != 0) begin
            failed++;
            $display("FAIL rstart_extra: got %0d events want 0", obs_q.size());
        end
    endtask

    task automatic test_timeout();
        ev_t e;
        ev_t o;
        int cf;
        int ct;
        cf = 0;
        ct = -1000;
        exp_q.delete();
        obs_q.delete();
        bus.sda_in = 1'b0;
        push(EV_START, 1'b0);
        clk_n(20);
        bus.scl_in = 1'b0;
        push(EV_FALL, 1'b0);
        push(EV_TO, 1'b0);
        clk_n(50);
        tests++;
        if (bus.bus_busy !== 1'b1) begin
            failed++;
            $display("FAIL timeout_busy_pre: got %b want 1", bus.bus_busy);
        end
        clk_n(80);
        tests++;
        if (bus.bus_busy !== 1'b0) begin
            failed++;
            $display("FAIL timeout_busy_post: got %b want 0", bus.bus_busy);
        end
        bus.scl_in = 1'b1;
        push(EV_RISE, 1'b0);
        push(EV_BIT, 1'b0);
        clk_n(10);
        bus.sda_in = 1'b1;
        push(EV_STOP, 1'b0);
        clk_n(150);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                failed++;
                $display("FAIL timeout_ev: got none want kind %0d", e.kind);
            end else begin
                o = obs_q.pop_front();
                if (o.kind == EV_FALL) cf = o.cyc;
                if (o.kind == EV_TO) ct = o.cyc;
                if (o.kind !== e.kind || o.data !== e.data) begin
                    failed++;
                    $display("FAIL timeout_ev: got %0d/%b want %0d/%b", o.kind, o.data, e.kind, e.data);
                end
            end
        end
        tests++;
        if (ct - cf !== TO) begin
            failed++;
            $display("FAIL timeout_delay: got %0d want %0d", ct - cf, TO);
        end
        tests++;
        if (obs_q.size() != 0) begin
            failed++;
            $display("FAIL timeout_extra: got %0d events want 0", obs_q.size());
        end
    endtask

    task automatic test_simultaneous();
        ev_t e;
        ev_t o;
        exp_q.delete();
        obs_q.delete();
        bus.scl_in = 1'b0;
        bus.sda_in = 1'b0;
        push(EV_FALL, 1'b0);
        clk_n(10);
        bus.sda_in = 1'b1;
        clk_n(10);
        bus.scl_in = 1'b1;
        push(EV_RISE, 1'b0);
        push(EV_BIT, 1'b1);
        clk_n(20);
        tests++;
        if (bus.bus_busy !== 1'b0) begin
            failed++;
            $display("FAIL simul_busy: got %b want 0", bus.bus_busy);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                failed++;
                $display("FAIL simul_ev: got none want kind %0d", e.kind);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.data !== e.data) begin
                    failed++;
                    $display("FAIL simul_ev: got %0d/%b want %0d/%b", o.kind, o.data, e.kind, e.data);
                end
            end
        end
        tests++;
        if (obs_q.size() != 0) begin
            failed++;
            $display("FAIL simul_extra: got %0d events want 0", obs_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bus.sda_in = 1'b0;
        clk_n(20);
        tests++;
        if (bus.bus_busy !== 1'b1) begin
            failed++;
            $display("FAIL rmid_busy_pre: got %b want 1", bus.bus_busy);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.bus_busy, bus.sda_s, bus.scl_s} !== 3'b011) begin
            failed++;
            $display("FAIL rmid_async: got %b want 011", {bus.bus_busy, bus.sda_s, bus.scl_s});
        end
        bus.sda_in = 1'b1;
        clk_n(3);
        obs_q.delete();
        rst_n = 1'b1;
        clk_n(10);
        tests++;
        if (obs_q.size() != 0 || bus.bus_busy !== 1'b0) begin
            failed++;
            $display("FAIL rmid_quiet: got %0d events busy %b want 0 events busy 0", obs_q.size(), bus.bus_busy);
        end
    endtask

    initial begin
        bus.scl_in = 1'b1;
        bus.sda_in = 1'b1;
        test_reset();
        test_byte();
        test_glitch();
        test_rstart();
        test_timeout();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
